// File: rtl/inert_intf_ctrl.sv
// Inertial sensor sequencer: power-up wait, register configuration, then on each
// data-ready interrupt reads PL/PH/AL/AH over the SPI master and publishes both words at once.
module inert_intf_ctrl #(
  parameter int INIT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               INT,
  input  logic               done,
  input  logic [15:0]        rd_data,
  output logic               wrt,
  output logic [15:0]        cmd,
  output logic signed [15:0] ptch_rt,
  output logic signed [15:0] AZ,
  output logic               vld,
  output logic [3:0]         dbg_state
);

  // Handshake: wrt is a one-cycle request with cmd valid alongside it; the SPI master
  // answers with a one-cycle done (rd_data valid in that cycle). One transaction in flight.

  typedef enum logic [3:0] {
    S_INIT_WAIT = 4'd0,
    S_CFG0      = 4'd1,
    S_CFG1      = 4'd2,
    S_CFG2      = 4'd3,
    S_CFG3      = 4'd4,
    S_IDLE      = 4'd5,
    S_RD_PL     = 4'd6,
    S_RD_PH     = 4'd7,
    S_RD_AL     = 4'd8,
    S_RD_AH     = 4'd9,
    S_PUB       = 4'd10
  } state_t;

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        int_ff1_q, int_ff1_d;
  logic        int_ff2_q, int_ff2_d;
  logic        wrt_q, wrt_d;
  logic        vld_q, vld_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] ptch_q, ptch_d;
  logic [15:0] az_q, az_d;
  logic [7:0]  pl_q, pl_d;
  logic [7:0]  ph_q, ph_d;
  logic [7:0]  al_q, al_d;
  logic        accept;
  logic        unused_rd_hi;

  function automatic logic is_txn(input state_t s);
    return (s inside {S_CFG0, S_CFG1, S_CFG2, S_CFG3, S_RD_PL, S_RD_PH, S_RD_AL, S_RD_AH});
  endfunction

  function automatic logic [15:0] cmd_of(input state_t s);
    case (s)
      S_CFG0:  return 16'h0D02;
      S_CFG1:  return 16'h1053;
      S_CFG2:  return 16'h1150;
      S_CFG3:  return 16'h1460;
      S_RD_PL: return 16'hA200;
      S_RD_PH: return 16'hA300;
      S_RD_AL: return 16'hAC00;
      S_RD_AH: return 16'hAD00;
      default: return 16'h0000;
    endcase
  endfunction

  assign unused_rd_hi = ^rd_data[15:8];

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    int_ff1_d = INT;
    int_ff2_d = int_ff1_q;
    wrt_d     = 1'b0;
    vld_d     = 1'b0;
    cmd_d     = cmd_q;
    ptch_d    = ptch_q;
    az_d      = az_q;
    pl_d      = pl_q;
    ph_d      = ph_q;
    al_d      = al_q;
    // done only counts once the request cycle is over
    accept    = is_txn(state_q) && !wrt_q && done;

    case (state_q)
      S_INIT_WAIT: begin
        if (timer_q == INIT_LAST) state_d = S_CFG0;
        else                      timer_d = timer_q + 16'd1;
      end
      S_CFG0: if (accept) state_d = S_CFG1;
      S_CFG1: if (accept) state_d = S_CFG2;
      S_CFG2: if (accept) state_d = S_CFG3;
      S_CFG3: if (accept) state_d = S_IDLE;
      S_IDLE: if (int_ff2_q) state_d = S_RD_PL;
      S_RD_PL: if (accept) begin
        pl_d    = rd_data[7:0];
        state_d = S_RD_PH;
      end
      S_RD_PH: if (accept) begin
        ph_d    = rd_data[7:0];
        state_d = S_RD_AL;
      end
      S_RD_AL: if (accept) begin
        al_d    = rd_data[7:0];
        state_d = S_RD_AH;
      end
      S_RD_AH: if (accept) begin
        ptch_d  = {ph_q, pl_q};
        az_d    = {rd_data[7:0], al_q};
        vld_d   = 1'b1;
        state_d = S_PUB;
      end
      S_PUB:   state_d = S_IDLE;
      default: state_d = S_INIT_WAIT;
    endcase

    // Request and command are registered on the edge that enters a transaction state
    if (state_d != state_q && is_txn(state_d)) begin
      wrt_d = 1'b1;
      cmd_d = cmd_of(state_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT_WAIT;
      timer_q   <= 16'h0000;
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      wrt_q     <= 1'b0;
      vld_q     <= 1'b0;
      cmd_q     <= 16'h0000;
      ptch_q    <= 16'h0000;
      az_q      <= 16'h0000;
      pl_q      <= 8'h00;
      ph_q      <= 8'h00;
      al_q      <= 8'h00;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      int_ff1_q <= int_ff1_d;
      int_ff2_q <= int_ff2_d;
      wrt_q     <= wrt_d;
      vld_q     <= vld_d;
      cmd_q     <= cmd_d;
      ptch_q    <= ptch_d;
      az_q      <= az_d;
      pl_q      <= pl_d;
      ph_q      <= ph_d;
      al_q      <= al_d;
    end
  end

  assign wrt       = wrt_q;
  assign vld       = vld_q;
  assign cmd       = cmd_q;
  assign ptch_rt   = ptch_q;
  assign AZ        = az_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inert_intf_ctrl.sv
// Randomized bench for inert_intf_ctrl: an SPI responder plus a command/sample
// reference model; inputs driven and outputs sampled on the falling clock edge.
module tb_inert_intf_ctrl;

  localparam int INIT_CYC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic signed [15:0] ptch_rt;
  logic signed [15:0] AZ;
  logic        vld;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_ptch;
  logic [15:0] cur_az;

  inert_intf_ctrl #(.INIT_CYCLES(INIT_CYC)) dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_wrt(input int limit, output int cycles);
    cycles = 0;
    while (wrt !== 1'b1 && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    check_val("wrt_seen", 16'(wrt), 16'd1);
  endtask

  // Serve one SPI transaction: wait for the request, answer with done after 'delay' cycles
  task automatic do_txn(input logic [7:0] b, input int delay, input int exp_lat, input bit spur);
    int lat;
    logic [15:0] exp_cmd;
    wait_wrt(200, lat);
    if (exp_lat >= 0) check_val("wrt_latency", 16'(lat), 16'(exp_lat));
    exp_cmd = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    check_val("cmd", cmd, exp_cmd);
    if (spur) begin
      done    = 1'b1;
      rd_data = {8'hEE, ~b};
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      done = 1'b0;
      check_val("no_wrt_outstanding", 16'(wrt), 16'd0);
    end
    check_val("cmd_stable", cmd, exp_cmd);
    done    = 1'b1;
    rd_data = {8'($urandom_range(0, 255)), b};
    @(negedge clk);
    done    = 1'b0;
    rd_data = 16'($urandom);
  endtask

  task automatic run_init(input int exp_lat);
    exp_q.push_back(16'h0D02);
    exp_q.push_back(16'h1053);
    exp_q.push_back(16'h1150);
    exp_q.push_back(16'h1460);
    do_txn(8'h00, 5, exp_lat, 1'b0);
    for (int i = 0; i < 3; i++) do_txn(8'h00, 5, 0, 1'b0);
  endtask

  task automatic idle_check(input int n);
    int wrt_cnt = 0;
    int vld_cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (wrt === 1'b1) wrt_cnt++;
      if (vld === 1'b1) vld_cnt++;
    end
    check_val("idle_no_wrt", 16'(wrt_cnt), 16'd0);
    check_val("idle_no_vld", 16'(vld_cnt), 16'd0);
  endtask

  // One full read sequence; the model publishes pitch = PH*256+PL, az = AH*256+AL
  task automatic read_seq(input logic [7:0] pl, input logic [7:0] ph, input logic [7:0] al,
                          input logic [7:0] ah, input int delay, input int exp_lat,
                          input bit keep_int, input bit spur);
    logic [15:0] exp_p;
    logic [15:0] exp_a;
    exp_q.push_back(16'hA200);
    exp_q.push_back(16'hA300);
    exp_q.push_back(16'hAC00);
    exp_q.push_back(16'hAD00);
    INT = 1'b1;
    do_txn(pl, delay, exp_lat, spur);
    INT = keep_int;
    do_txn(ph, delay, 0, 1'b0);
    do_txn(al, delay, 0, 1'b0);
    check_val("ptch_before_pub", ptch_rt, cur_ptch);
    check_val("az_before_pub", AZ, cur_az);
    check_val("vld_before_pub", 16'(vld), 16'd0);
    do_txn(ah, delay, 0, 1'b0);
    exp_p = 16'(int'(ph) * 256 + int'(pl));
    exp_a = 16'(int'(ah) * 256 + int'(al));
    check_val("vld_pulse", 16'(vld), 16'd1);
    check_val("ptch_rt", ptch_rt, exp_p);
    check_val("AZ", AZ, exp_a);
    cur_ptch = exp_p;
    cur_az   = exp_a;
    @(negedge clk);
    check_val("vld_single", 16'(vld), 16'd0);
    check_val("ptch_held", ptch_rt, cur_ptch);
    check_val("az_held", AZ, cur_az);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    rst      = 1'b1;
    INT      = 1'b0;
    done     = 1'b0;
    rd_data  = 16'h0000;
    cur_ptch = 16'h0000;
    cur_az   = 16'h0000;
    repeat (3) @(negedge clk);
    check_val("rst_wrt", 16'(wrt), 16'd0);
    check_val("rst_vld", 16'(vld), 16'd0);
    check_val("rst_cmd", cmd, 16'h0000);
    check_val("rst_ptch", ptch_rt, 16'h0000);
    check_val("rst_az", AZ, 16'h0000);
    rst = 1'b0;

    run_init(INIT_CYC);
    idle_check(20);

    // spurious done while idle
    done    = 1'b1;
    rd_data = 16'h00AA;
    @(negedge clk);
    done = 1'b0;
    idle_check(8);

    // directed reads, the first with a spurious done in its request cycle
    read_seq(8'hC2, 8'h03, 8'h80, 8'hFE, 4, 3, 1'b0, 1'b1);
    idle_check(6);
    read_seq(8'h00, 8'h80, 8'h01, 8'h80, 2, 3, 1'b0, 1'b0);
    idle_check(6);

    // back-to-back with INT held high
    read_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3, 3, 1'b1, 1'b0);
    read_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1, 1, 1'b1, 1'b0);
    read_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2, 1, 1'b0, 1'b0);
    idle_check(10);

    // randomized reads
    for (int k = 0; k < 6; k++) begin
      read_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(1, 8), 3, 1'b0, 1'b0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // reset in the middle of the PH read
    exp_q.push_back(16'hA200);
    exp_q.push_back(16'hA300);
    INT = 1'b1;
    do_txn(8'h11, 3, 3, 1'b0);
    INT = 1'b0;
    wait_wrt(200, lat);
    check_val("cmd_rd_ph", cmd, exp_q.pop_front());
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_wrt", 16'(wrt), 16'd0);
    check_val("async_rst_vld", 16'(vld), 16'd0);
    check_val("async_rst_cmd", cmd, 16'h0000);
    check_val("async_rst_ptch", ptch_rt, 16'h0000);
    check_val("async_rst_az", AZ, 16'h0000);
    @(negedge clk);
    done    = 1'b1;
    rd_data = 16'h0055;
    @(negedge clk);
    done = 1'b0;
    check_val("rst_vld_low", 16'(vld), 16'd0);
    cur_ptch = 16'h0000;
    cur_az   = 16'h0000;
    exp_q.delete();
    rst = 1'b0;
    run_init(INIT_CYC);
    idle_check(5);
    read_seq(8'h34, 8'h12, 8'h78, 8'h56, 3, 3, 1'b0, 1'b0);
    idle_check(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inert_intf_ctrl.md
# inert_intf_ctrl

Sequences the inertial sensor over the existing SPI transaction master and delivers raw signed pitch-rate and Z-acceleration samples, with a one-cycle `vld` strobe, to the inertial integrator directly downstream. After reset it waits for sensor power-up and writes the configuration registers. It then loops: on each sensor data-ready interrupt it reads four byte registers and publishes both 16-bit words atomically.

## Interface
- `INIT_CYCLES`, default 65535: clk cycles to wait after reset before the first config write (16-bit counter).
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `INT` input 1: sensor data-ready, asynchronous, level-sensitive.
- `done` input 1: SPI master single-cycle pulse, transaction complete.
- `rd_data` input 16: SPI master read data, valid in the `done` cycle; only `[7:0]` used.
- `wrt` output 1: single-cycle pulse that starts an SPI transaction.
- `cmd` output 16: SPI command word, registered.
- `ptch_rt` output 16 signed: pitch rate, `{PH,PL}`.
- `AZ` output 16 signed: Z acceleration, `{AH,AL}`.
- `vld` output 1: single-cycle strobe, new `ptch_rt`/`AZ` valid.

## Operation
- `INT` passes through two synchronizer flops (`INT_ff1`, `INT_ff2`). The FSM uses `INT_ff2` only.
- FSM states and transitions:
  - INIT_WAIT: counts up to INIT_CYCLES-1, then goes to CFG0.
  - CFG0 `16'h0D02` (INT enable) -> CFG1 `16'h1053` (accel) -> CFG2 `16'h1150` (gyro) -> CFG3 `16'h1460` (rounding) -> IDLE.
  - IDLE: when `INT_ff2`=1, go to RD_PL `16'hA2xx`.
  - RD_PL -> RD_PH `16'hA3xx` -> RD_AL `16'hACxx` -> RD_AH `16'hADxx` -> PUB -> IDLE.
  - Read commands carry `8'h00` in `[7:0]`.
- Transaction sub-protocol in every CFG/RD state:
  - `wrt`=1 for exactly the first cycle of the state, and `cmd` loads the state's word on the same edge.
  - The FSM then waits for `done`. On `done` it captures `rd_data[7:0]` into that state's staging byte (RD states only) and advances.
- PUB lasts one cycle:
  - `ptch_rt` <= `{PH,PL}` and `AZ` <= `{AH,AL}` update on the same edge that raises `vld`.
  - Outputs are otherwise held. No partial update is ever visible.
- `done` outside a waiting state (INIT_WAIT, IDLE, PUB, or the `wrt` cycle itself) is ignored.
- `INT` is level-sensitive. If `INT_ff2` is still high in IDLE after PUB, a new read starts immediately, because the sensor clears INT on data read.
- No arithmetic or offset removal is done here; the raw bytes are concatenated. Offset compensation belongs downstream.

## Timing
- Reset values:
  - `wrt`=0, `vld`=0, `cmd`=16'h0000, `ptch_rt`=16'h0000, `AZ`=16'h0000.
  - Staging bytes 0, synchronizer 0, timer 0, state INIT_WAIT.
- First `wrt` occurs INIT_CYCLES cycles after `rst` deasserts.
- `cmd` is stable from the `wrt` cycle through the `done` cycle.
- Next `wrt` is asserted in the cycle immediately after the `done` cycle (one-cycle gap minimum). `wrt` never asserts while a transaction is outstanding.
- INT latency: `INT` high before edge k puts `INT_ff2` high after edge k+1. The FSM leaves IDLE at edge k+2, so `wrt` is high in the cycle after edge k+2.
- `vld` is high for the one cycle after the RD_AH `done` edge.
- `rst` mid-operation:
  - Immediate return to reset values.
  - Any in-flight `done` is ignored.
  - Full init sequence repeats, including the INIT_CYCLES wait.
- `INT` toggling during a read sequence has no effect until IDLE.

## Test plan
- Reset: assert `rst` mid-RD_PH. All outputs go 0 asynchronously, `vld` stays low. After release with INIT_CYCLES=16, the first `wrt` comes 16 cycles later with `cmd`=16'h0D02.
- Init: respond to each `wrt` with `done` 5 cycles later. `cmd` sequence is exactly 0D02, 1053, 1150, 1460. `wrt` is never asserted without a preceding `done`. FSM then idles with no `wrt` while INT=0.
- Read:
  - INT=1 and `rd_data` low bytes C2, 03, 80, FE. `cmd` sequence is A2xx, A3xx, ACxx, ADxx.
  - One `vld` pulse with `ptch_rt`=16'h03C2 and `AZ`=16'hFE80.
  - Outputs are unchanged before the `vld` edge and held afterward.
- Negative values: bytes 00, 80, 01, 80 give `ptch_rt`=16'h8000 (-32768) and `AZ`=16'h8001.
- Spurious `done`: pulse `done` in IDLE and in the `wrt` cycle. There is no state advance and no `vld`, and the staging bytes are unchanged.
- Back-to-back: hold INT=1 continuously. The second read sequence's first `wrt` arrives 2 cycles after `vld` (PUB cycle, then IDLE), giving repeated `vld` pulses with fresh data.
